// File: rtl/serial_link_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : serial_link_sequencer
// Brief   : Half-duplex serial transaction sequencer that sends a frame, turns
//           the pad around, and optionally captures a response frame.
// Rev     : 1.0
// ============================================================================
module serial_link_sequencer #(
    parameter int WIDTH   = 64,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] tx_data,
    input  logic [7:0]       tx_size,
    input  logic [7:0]       rx_size,
    output logic [WIDTH-1:0] pts_parallel,
    output logic             pts_load,
    output logic             pad_oe,
    output logic             stp_enable,
    output logic [7:0]       stp_framesize,
    input  logic             stp_complete,
    input  logic [WIDTH-1:0] stp_parallel,
    input  logic             line_in,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [WIDTH-1:0] rx_data
);

    localparam int               TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [7:0]       c_width    = 8'(WIDTH);
    localparam logic [TW-1:0]    c_tmo_last = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        SEND       = 3'd2,
        TURN       = 3'd3,
        WAIT_START = 3'd4,
        RECV       = 3'd5,
        DONE       = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_tmo_hit;
    logic [7:0]        w_tx_len;
    logic [7:0]        w_rx_len;
    logic [7:0]        r_tx_len;
    logic [7:0]        r_rx_len;
    logic [7:0]        r_bit_cnt;
    logic [TW-1:0]     r_timer;
    logic              r_tmo_flag;
    logic [WIDTH-1:0]  r_pts_parallel;
    logic [WIDTH-1:0]  r_rx_data;

    // Out-of-range sizes fall back to a full frame; rx_size 0 keeps meaning "no response".
    assign w_tx_len = (tx_size == 8'd0 || int'(tx_size) > WIDTH) ? c_width : tx_size;
    assign w_rx_len = (int'(rx_size) > WIDTH) ? c_width : rx_size;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_tmo_hit   = 1'b0;
        pts_load    = 1'b0;
        pad_oe      = 1'b0;
        stp_enable  = 1'b0;
        busy        = (r_state != IDLE);
        done        = 1'b0;
        timeout_err = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !abort) w_next = LOAD;
            end
            LOAD: begin
                pad_oe = 1'b1;
                w_next = SEND;
            end
            SEND: begin
                pts_load = 1'b1;
                pad_oe   = 1'b1;
                if (r_bit_cnt == r_tx_len - 8'd1) w_next = TURN;
            end
            TURN: begin
                if (r_bit_cnt == 8'd1) w_next = (r_rx_len != 8'd0) ? WAIT_START : DONE;
            end
            WAIT_START: begin
                if (!line_in) begin
                    w_next = RECV;
                end else if (r_timer == c_tmo_last) begin
                    w_next    = DONE;
                    w_tmo_hit = 1'b1;
                end
            end
            RECV: begin
                stp_enable = 1'b1;
                if (stp_complete) w_next = DONE;
            end
            DONE: begin
                done        = 1'b1;
                timeout_err = r_tmo_flag;
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // Abort overrides every other exit condition evaluated above.
        if (abort && r_state != IDLE) begin
            w_next    = IDLE;
            w_tmo_hit = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_len       <= 8'd0;
            r_rx_len       <= 8'd0;
            r_bit_cnt      <= 8'd0;
            r_timer        <= '0;
            r_tmo_flag     <= 1'b0;
            r_pts_parallel <= '0;
            r_rx_data      <= '0;
        end else begin
            if (r_state == IDLE && start && !abort) begin
                r_pts_parallel <= tx_data;
                r_tx_len       <= w_tx_len;
                r_rx_len       <= w_rx_len;
            end
            // Counters restart on every state change so each phase counts from zero.
            if (w_next != r_state) begin
                r_bit_cnt <= 8'd0;
                r_timer   <= '0;
            end else if (r_state == SEND || r_state == TURN) begin
                r_bit_cnt <= r_bit_cnt + 8'd1;
            end else if (r_state == WAIT_START) begin
                r_timer <= r_timer + 1'b1;
            end
            if (r_state == RECV && stp_complete && !abort) begin
                r_rx_data <= stp_parallel;
            end
            if (w_next == DONE) begin
                r_tmo_flag <= w_tmo_hit;
            end
        end
    end

    assign pts_parallel  = r_pts_parallel;
    assign stp_framesize = r_rx_len;
    assign rx_data       = r_rx_data;

endmodule
`default_nettype wire

// File: tb/tb_serial_link_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_link_sequencer
// Brief   : Directed self-checking bench for serial_link_sequencer.
// Rev     : 1.0
// ============================================================================
module tb_serial_link_sequencer;

    localparam int WIDTH   = 64;
    localparam int TIMEOUT = 64;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] tx_data;
    logic [7:0]       tx_size;
    logic [7:0]       rx_size;
    logic [WIDTH-1:0] pts_parallel;
    logic             pts_load;
    logic             pad_oe;
    logic             stp_enable;
    logic [7:0]       stp_framesize;
    logic             stp_complete;
    logic [WIDTH-1:0] stp_parallel;
    logic             line_in;
    logic             busy;
    logic             done;
    logic             timeout_err;
    logic [WIDTH-1:0] rx_data;

    int checks = 0;
    int errors = 0;

    serial_link_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .tx_data       (tx_data),
        .tx_size       (tx_size),
        .rx_size       (rx_size),
        .pts_parallel  (pts_parallel),
        .pts_load      (pts_load),
        .pad_oe        (pad_oe),
        .stp_enable    (stp_enable),
        .stp_framesize (stp_framesize),
        .stp_complete  (stp_complete),
        .stp_parallel  (stp_parallel),
        .line_in       (line_in),
        .busy          (busy),
        .done          (done),
        .timeout_err   (timeout_err),
        .rx_data       (rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Launches one transaction from a negedge and steps until done (bounded).
    task automatic run_txn(input logic [63:0] d, input logic [7:0] ts, input logic [7:0] rs,
                           input int pulse_at, input bit pulse_in_done,
                           output int n_total, output int n_load, output int n_line,
                           output bit got_done, output bit got_tmo);
        tx_data  = d;
        tx_size  = ts;
        rx_size  = rs;
        start    = 1'b1;
        n_total  = 1;
        n_load   = 0;
        n_line   = 0;
        got_done = 1'b0;
        got_tmo  = 1'b0;
        while (n_total < 500 && !got_done) begin
            @(negedge clk);
            n_total++;
            start = (n_total == pulse_at);
            if (pts_load) n_load++;
            if (busy && !pad_oe && !pts_load && !stp_enable && !done) n_line++;
            if (done) begin
                got_done = 1'b1;
                got_tmo  = timeout_err;
                if (pulse_in_done) start = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    int n_total, n_load, n_line;
    bit got_done, got_tmo;

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        tx_data      = '0;
        tx_size      = 8'd0;
        rx_size      = 8'd0;
        stp_complete = 1'b0;
        stp_parallel = '0;
        line_in      = 1'b1;

        // Reset state
        step(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_oe", pad_oe, 0);
        check("rst_load", pts_load, 0);
        check("rst_stp_en", stp_enable, 0);
        check("rst_tmo", timeout_err, 0);
        check("rst_pts_par", pts_parallel, 0);
        check("rst_framesize", stp_framesize, 0);
        check("rst_rx_data", rx_data, 0);
        rst_n = 1'b1;
        step(1);

        // Full-width send, no response
        run_txn(64'hF0F0F0F0F0F0F0F0, 8'd64, 8'd0, 0, 1'b0, n_total, n_load, n_line, got_done, got_tmo);
        check("t1_done", got_done, 1);
        check("t1_total", n_total, 69);
        check("t1_load_cycles", n_load, 64);
        check("t1_turn_cycles", n_line, 2);
        check("t1_tmo", got_tmo, 0);
        check("t1_pts_par", pts_parallel, 64'hF0F0F0F0F0F0F0F0);
        check("t1_idle", busy, 0);

        // 48-bit send followed by a 64-bit response
        tx_data = 64'hA5A5_0000_1111_2222;
        tx_size = 8'd48;
        rx_size = 8'd64;
        start   = 1'b1;
        step(1);
        start = 1'b0;
        check("t2_load_pts", pts_load, 0);
        check("t2_load_oe", pad_oe, 1);
        check("t2_pts_par", pts_parallel, 64'hA5A5_0000_1111_2222);
        step(48);
        check("t2_last_send", pts_load, 1);
        step(1);
        check("t2_turn_oe", pad_oe, 0);
        check("t2_turn_load", pts_load, 0);
        step(2);
        check("t2_framesize", stp_framesize, 64);
        check("t2_wait_stp_en", stp_enable, 0);
        step(4);
        check("t2_wait_busy", busy, 1);
        line_in = 1'b0;
        step(1);
        line_in = 1'b1;
        check("t2_recv_stp_en", stp_enable, 1);
        check("t2_recv_oe", pad_oe, 0);
        step(2);
        check("t2_recv_hold", stp_enable, 1);
        stp_parallel = 64'h0123456789ABCDEF;
        stp_complete = 1'b1;
        step(1);
        stp_complete = 1'b0;
        check("t2_done", done, 1);
        check("t2_tmo", timeout_err, 0);
        check("t2_rx_data", rx_data, 64'h0123456789ABCDEF);
        step(1);
        check("t2_idle_busy", busy, 0);
        check("t2_idle_done", done, 0);

        // Response start bit never arrives
        stp_parallel = 64'hDEAD_BEEF_DEAD_BEEF;
        run_txn(64'h1, 8'd8, 8'd8, 0, 1'b0, n_total, n_load, n_line, got_done, got_tmo);
        check("t3_done", got_done, 1);
        check("t3_tmo", got_tmo, 1);
        check("t3_total", n_total, 77);
        check("t3_line_cycles", n_line, 2 + TIMEOUT);
        check("t3_rx_kept", rx_data, 64'h0123456789ABCDEF);
        check("t3_tmo_cleared", timeout_err, 0);

        // Abort on the 10th SEND cycle
        tx_size = 8'd64;
        rx_size = 8'd0;
        start   = 1'b1;
        step(1);
        start = 1'b0;
        step(10);
        check("t4_send10", pts_load, 1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("t4_abort_busy", busy, 0);
        check("t4_abort_load", pts_load, 0);
        check("t4_abort_oe", pad_oe, 0);
        check("t4_abort_done", done, 0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("t4_restart_busy", busy, 1);
        check("t4_restart_oe", pad_oe, 1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("t4_abort2_busy", busy, 0);
        check("t4_rx_kept", rx_data, 64'h0123456789ABCDEF);
        start = 1'b1;
        abort = 1'b1;
        step(1);
        start = 1'b0;
        abort = 1'b0;
        check("t4_start_abort_idle", busy, 0);

        // Size clamping and ignored starts while busy / in DONE
        run_txn(64'h3C3C, 8'd0, 8'd0, 20, 1'b0, n_total, n_load, n_line, got_done, got_tmo);
        check("t5a_load_cycles", n_load, 64);
        check("t5a_total", n_total, 69);
        check("t5a_no_second", busy, 0);
        run_txn(64'h3C3C, 8'd200, 8'd0, 0, 1'b1, n_total, n_load, n_line, got_done, got_tmo);
        check("t5b_load_cycles", n_load, 64);
        check("t5b_total", n_total, 69);
        check("t5b_not_queued", busy, 0);

        // Asynchronous reset in the middle of RECV
        tx_size = 8'd8;
        rx_size = 8'd8;
        start   = 1'b1;
        step(1);
        start = 1'b0;
        step(11);
        line_in = 1'b0;
        step(1);
        check("t6_in_recv", stp_enable, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_stp_en", stp_enable, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_oe", pad_oe, 0);
        check("t6_async_rx", rx_data, 0);
        check("t6_async_framesize", stp_framesize, 0);
        check("t6_async_pts_par", pts_parallel, 0);
        line_in      = 1'b1;
        stp_complete = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        stp_complete = 1'b0;
        check("t6_post_busy", busy, 0);
        check("t6_post_done", done, 0);
        check("t6_post_rx", rx_data, 0);

        // First start right after reset release
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("t7_first_start", busy, 1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("t7_abort_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
